// File: rtl/dipsw_poll_ctrl.sv
// Polls a 4-bit input PIO over Avalon-MM, debounces it, and captures edges in a CSR block.
// Optional feature macro: DIPSW_POLL_IRQ_EN (irq mask register and registered level interrupt).
module dipsw_poll_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PERIOD     = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, CAPT, EVAL} state_t;

  state_t           state, state_next;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] sample, candidate, debounced, edge_cap;
  logic [3:0]       match_cnt;
  logic             enable;

  logic             tick, force_poll, accept;
  logic             wr_mask, wr_edge, wr_ctrl;
  logic [3:0]       cnt_inc;
  logic [WIDTH-1:0] edge_set, edge_clr, edge_next;
  logic [31:0]      rd_data;

  assign tick       = (timer == TW'(PERIOD - 1));
  assign wr_mask    = s_write && (s_address == 2'd1);
  assign wr_edge    = s_write && (s_address == 2'd2);
  assign wr_ctrl    = s_write && (s_address == 2'd3);
  assign force_poll = wr_ctrl && s_writedata[1];

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if ((tick && enable) || force_poll) state_next = ADDR;
      ADDR: state_next = CAPT;
      CAPT: state_next = EVAL;
      EVAL: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // PIO returns 0 at address 1, so the bus idles there between polls.
  assign m_address = (state == ADDR || state == CAPT) ? 2'd0 : 2'd1;

  assign cnt_inc  = (match_cnt >= 4'(STABLE_CNT)) ? 4'(STABLE_CNT) : match_cnt + 4'd1;
  assign accept   = (state == EVAL) && (sample == candidate) &&
                    (cnt_inc == 4'(STABLE_CNT)) && (candidate != debounced);
  assign edge_set = accept ? (candidate ^ debounced) : '0;
  assign edge_clr = wr_edge ? s_writedata[WIDTH-1:0] : '0;
  // Clear is applied before set so a new edge in the same cycle survives the W1C.
  assign edge_next = (edge_cap & ~edge_clr) | edge_set;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      sample    <= '0;
      candidate <= '0;
      debounced <= '0;
      match_cnt <= '0;
      edge_cap  <= '0;
      enable    <= 1'b1;
    end else begin
      state    <= state_next;
      timer    <= tick ? '0 : timer + TW'(1);
      edge_cap <= edge_next;
      if (wr_ctrl) enable <= s_writedata[0];
      if (state == CAPT) sample <= m_readdata[WIDTH-1:0];
      if (state == EVAL) begin
        if (sample != candidate) begin
          candidate <= sample;
          match_cnt <= 4'd1;
        end else begin
          match_cnt <= cnt_inc;
        end
        if (accept) debounced <= candidate;
      end
    end
  end

`ifdef DIPSW_POLL_IRQ_EN
  logic [WIDTH-1:0] mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr_mask) mask <= s_writedata[WIDTH-1:0];
      irq <= |(edge_cap & mask);
    end
  end

  always_comb begin
    rd_data = '0;
    case (s_address)
      2'd0: rd_data[WIDTH-1:0] = debounced;
      2'd1: rd_data[WIDTH-1:0] = mask;
      2'd2: rd_data[WIDTH-1:0] = edge_cap;
      2'd3: rd_data[0]         = enable;
      default: rd_data = '0;
    endcase
  end
`else
  // Without the mask there is no interrupt; software polls the edge register.
  assign irq = 1'b0;

  always_comb begin
    rd_data = '0;
    case (s_address)
      2'd0: rd_data[WIDTH-1:0] = debounced;
      2'd2: rd_data[WIDTH-1:0] = edge_cap;
      2'd3: rd_data[0]         = enable;
      default: rd_data = '0;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s_readdata <= '0;
    else          s_readdata <= rd_data;
  end

endmodule

// File: tb/tb_dipsw_poll_ctrl.sv
// Directed bench for dipsw_poll_ctrl (PERIOD=16, STABLE_CNT=3) with a registered PIO model.
module tb_dipsw_poll_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  m_address;
  logic [31:0] m_readdata = '0;
  logic [1:0]  s_address = '0;
  logic        s_write = 1'b0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        irq;
  logic [3:0]  sw = 4'hA;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef DIPSW_POLL_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  dipsw_poll_ctrl #(.WIDTH(4), .PERIOD(16), .STABLE_CNT(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .m_address(m_address), .m_readdata(m_readdata),
    .s_address(s_address), .s_write(s_write), .s_writedata(s_writedata),
    .s_readdata(s_readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  // PIO s1: registered readdata, switches at address 0, zero elsewhere.
  always @(posedge clk) m_readdata <= (m_address == 2'd0) ? {28'd0, sw} : 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // All tasks start and end on a falling edge.
  task automatic csr_write(input logic [1:0] addr, input logic [31:0] data);
    s_address = addr; s_writedata = data; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0; s_writedata = '0;
  endtask

  task automatic csr_read(input logic [1:0] addr, output logic [31:0] data);
    s_address = addr;
    @(negedge clk);
    data = s_readdata;
  endtask

  // Returns on the falling edge inside EVAL of the next poll.
  task automatic wait_eval();
    logic prev;
    bit   found;
    prev  = (m_address == 2'd0);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (prev && m_address == 2'd1) found = 1'b1;
      prev = (m_address == 2'd0);
    end
    if (!found) check("eval_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int low_cycles, k;

    // 1: reset, switches 0xA, mask 0xF
    repeat (3) @(negedge clk);
    check("rst_m_address", {30'd0, m_address}, 32'd1);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_readdata", s_readdata, 32'd0);
    reset_n = 1'b1;
    csr_write(2'd1, 32'hF);
    csr_read(2'd3, rd);  check("ctrl_reset", rd, 32'd1);
    wait_eval();
    wait_eval();
    csr_read(2'd0, rd);  check("deb_after_2", rd, 32'd0);
    wait_eval();
    @(negedge clk);
    check("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_set", {31'd0, irq}, {31'd0, IRQ_EN});
    csr_read(2'd0, rd);  check("deb_after_3", rd, 32'hA);
    csr_read(2'd2, rd);  check("edge_first", rd, 32'hA);
    csr_read(2'd1, rd);  check("mask_read", rd, IRQ_EN ? 32'hF : 32'h0);

    // 2: one-poll glitch to 0x5 is rejected
    wait_eval();
    sw = 4'h5;
    wait_eval();
    sw = 4'hA;
    repeat (3) wait_eval();
    @(negedge clk);
    csr_read(2'd0, rd);  check("glitch_deb", rd, 32'hA);
    csr_read(2'd2, rd);  check("glitch_edge", rd, 32'hA);
    check("glitch_irq", {31'd0, irq}, {31'd0, IRQ_EN});

    // 3: W1C, then clear colliding with a new bit1 edge
    csr_write(2'd2, 32'h2);
    csr_read(2'd2, rd);  check("w1c_clear", rd, 32'h8);
    wait_eval();
    sw = 4'h8;
    wait_eval();
    wait_eval();
    wait_eval();
    csr_write(2'd2, 32'h2);
    csr_read(2'd2, rd);  check("w1c_set_wins", rd, 32'hA);
    csr_read(2'd0, rd);  check("deb_0x8", rd, 32'h8);

    // 5: mask gating of irq (edge driven to 0xF first)
    wait_eval();
    sw = 4'h5;
    repeat (3) wait_eval();
    @(negedge clk);
    csr_read(2'd0, rd);  check("deb_0x5", rd, 32'h5);
    csr_read(2'd2, rd);  check("edge_all", rd, 32'hF);
    csr_write(2'd1, 32'h0);
    @(negedge clk);
    check("irq_masked", {31'd0, irq}, 32'd0);
    csr_write(2'd1, 32'h8);
    check("irq_pre_mask", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_unmasked", {31'd0, irq}, {31'd0, IRQ_EN});
    csr_read(2'd1, rd);  check("mask_0x8", rd, IRQ_EN ? 32'h8 : 32'h0);
    csr_write(2'd0, 32'hF);
    csr_read(2'd0, rd);  check("deb_ro", rd, 32'h5);

    // 4: disabled timer, single forced poll
    wait_eval();
    csr_write(2'd3, 32'h0);
    low_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_address == 2'd0) low_cycles++;
    end
    check("disabled_no_poll", low_cycles, 0);
    csr_write(2'd3, 32'h2);
    check("force_starts", {30'd0, m_address}, 32'd0);
    low_cycles = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (m_address == 2'd0) low_cycles++;
    end
    check("force_one_poll", low_cycles, 2);
    csr_read(2'd3, rd);  check("ctrl_after_force", rd, 32'h0);
    csr_write(2'd3, 32'h1);
    csr_read(2'd3, rd);  check("ctrl_reenable", rd, 32'h1);

    // 6: reset during CAPT, then first poll at terminal count
    k = 0;
    while (m_address != 2'd0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("find_addr", (k < 100) ? 32'd1 : 32'd0, 32'd1);
    @(negedge clk);
    check("in_capt", {30'd0, m_address}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("abort_m_address", {30'd0, m_address}, 32'd1);
    check("abort_irq", {31'd0, irq}, 32'd0);
    check("abort_readdata", s_readdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge clk);
      if (m_address == 2'd0) k = i;
    end
    check("first_poll_delay", k, 16);
    csr_read(2'd0, rd);  check("post_rst_deb", rd, 32'h0);
    csr_read(2'd1, rd);  check("post_rst_mask", rd, 32'h0);
    csr_read(2'd2, rd);  check("post_rst_edge", rd, 32'h0);
    csr_read(2'd3, rd);  check("post_rst_ctrl", rd, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
